// File: rtl/fetch_stage_pkg.sv
// Shared types, constants and helpers for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned RS_LSB      = 21;
    localparam int unsigned RT_LSB      = 16;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        DROP  = 2'b11
    } fetchState_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifIdReg_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential PC, wraps modulo 2^32.
    function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word that returns while the pipe is stalled.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Load,
    input  logic            Clear,
    input  logic [XLEN-1:0] DataIn,
    output logic [XLEN-1:0] Data,
    output logic            Valid
);

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Data  <= NOP_INSTR;
            Valid <= 1'b0;
        end else if (Clear) begin
            Data  <= NOP_INSTR;
            Valid <= 1'b0;
        end else if (Load) begin
            Data  <= DataIn;
            Valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding memory request FSM, skid buffer and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [XLEN-1:0]      BranchTarget,
    output logic                 ImemReq,
    output logic [XLEN-1:0]      ImemAddr,
    input  logic [XLEN-1:0]      ImemData,
    input  logic                 ImemValid,
    output logic [XLEN-1:0]      IF_ID_Instr,
    output logic [XLEN-1:0]      IF_ID_PC4,
    output logic                 IF_ID_Valid,
    output logic [REG_IDX_W-1:0] IF_ID_Rs,
    output logic [REG_IDX_W-1:0] IF_ID_Rt
);

    fetchState_t     stateQ, stateD;
    logic [XLEN-1:0] pcQ, pcD;
    ifIdReg_t        ifIdQ, ifIdD;
    logic            imemReqQ, imemReqD;
    logic            skidLoad, skidClear;
    logic [XLEN-1:0] skidData;
    logic            skidValid;
    logic [XLEN-1:0] pcPlus4;

    assign pcPlus4 = nextPc(pcQ);

    fetch_skid_buffer uSkid (
        .Clk    (Clk),
        .Rst    (Rst),
        .Load   (skidLoad),
        .Clear  (skidClear),
        .DataIn (ImemData),
        .Data   (skidData),
        .Valid  (skidValid)
    );

    // State, PC, request and IF/ID registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stateQ   <= IDLE;
            pcQ      <= RESET_PC;
            imemReqQ <= 1'b0;
            ifIdQ    <= '{instr: NOP_INSTR, pc4: RESET_PC, valid: 1'b0};
        end else begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            imemReqQ <= imemReqD;
            ifIdQ    <= ifIdD;
        end
    end

    // Next-state, PC and IF/ID update; a redirect takes priority over stall and returned data.
    always_comb begin
        stateD    = stateQ;
        pcD       = pcQ;
        ifIdD     = ifIdQ;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        imemReqD  = 1'b0;

        if (BranchTaken) begin
            pcD       = alignPc(BranchTarget);
            skidClear = 1'b1;
            if (stateQ != DROP) begin
                ifIdD.instr = NOP_INSTR;
                ifIdD.valid = 1'b0;
            end
            // A request still in flight must have its word discarded in DROP.
            if ((stateQ == FETCH || stateQ == DROP) && !ImemValid) begin
                stateD = DROP;
            end else begin
                stateD = FETCH;
            end
        end else begin
            case (stateQ)
                IDLE: begin
                    stateD = FETCH;
                end
                FETCH: begin
                    if (ImemValid) begin
                        if (Stall) begin
                            skidLoad = 1'b1;
                            stateD   = HOLD;
                        end else begin
                            ifIdD.instr = ImemData;
                            ifIdD.pc4   = pcPlus4;
                            ifIdD.valid = 1'b1;
                            pcD         = pcPlus4;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        ifIdD.instr = skidData;
                        ifIdD.pc4   = pcPlus4;
                        ifIdD.valid = skidValid;
                        pcD         = pcPlus4;
                        skidClear   = 1'b1;
                        stateD      = FETCH;
                    end
                end
                DROP: begin
                    if (ImemValid) begin
                        stateD = FETCH;
                    end
                end
                default: begin
                    stateD = IDLE;
                end
            endcase
        end

        imemReqD = (stateD == FETCH);
    end

    assign ImemReq     = imemReqQ;
    assign ImemAddr    = pcQ;
    assign IF_ID_Instr = ifIdQ.instr;
    assign IF_ID_PC4   = ifIdQ.pc4;
    assign IF_ID_Valid = ifIdQ.valid;
    assign IF_ID_Rs    = ifIdQ.instr[RS_LSB +: REG_IDX_W];
    assign IF_ID_Rt    = ifIdQ.instr[RT_LSB +: REG_IDX_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-accurate vector bench for fetch_stage with an expected-output scoreboard queue.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic        ImemValid;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_Rs;
    logic [4:0]  IF_ID_Rt;

    fetch_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemData     (ImemData),
        .ImemValid    (ImemValid),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_PC4    (IF_ID_PC4),
        .IF_ID_Valid  (IF_ID_Valid),
        .IF_ID_Rs     (IF_ID_Rs),
        .IF_ID_Rt     (IF_ID_Rt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        iv;
        logic [31:0] data;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic [31:0] expPc4;
        logic        chkPc4;
        logic        expValid;
    } vec_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chkPc4;
        logic        valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   stepIdx = 0;

    // Instruction memory contents: distinct rs/rt fields per address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [4:0] f;
        f = a[6:2];
        return {6'h23, f, ~f, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] tgt, input logic iv, input logic [31:0] data,
                                input logic req, input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic chk, input logic valid);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.iv = iv; v.data = data;
        v.expReq = req; v.expAddr = addr; v.expInstr = instr; v.expPc4 = pc4;
        v.chkPc4 = chk; v.expValid = valid;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expectation, then compare after the edge.
    task automatic applyVec(input vec_t v);
        exp_t e;
        logic [31:0] ins;
        Rst = v.rst; Stall = v.stall; BranchTaken = v.br; BranchTarget = v.tgt;
        ImemValid = v.iv; ImemData = v.data;
        e.idx = stepIdx; e.req = v.expReq; e.addr = v.expAddr; e.instr = v.expInstr;
        e.pc4 = v.expPc4; e.chkPc4 = v.chkPc4; e.valid = v.expValid;
        sb.push_back(e);
        stepIdx++;
        @(posedge Clk);
        #1;
        nChecks++;
        if (sb.size() == 0) begin
            nFails++;
            $display("FAIL scoreboard step %0d: got empty queue, expected an entry", stepIdx - 1);
        end else begin
            e = sb.pop_front();
            ins = e.instr;
            chk("ImemReq",     e.idx, 32'(ImemReq),     32'(e.req));
            chk("ImemAddr",    e.idx, ImemAddr,         e.addr);
            chk("IF_ID_Instr", e.idx, IF_ID_Instr,      e.instr);
            chk("IF_ID_Valid", e.idx, 32'(IF_ID_Valid), 32'(e.valid));
            chk("IF_ID_Rs",    e.idx, 32'(IF_ID_Rs),    32'(ins[25:21]));
            chk("IF_ID_Rt",    e.idx, 32'(IF_ID_Rt),    32'(ins[20:16]));
            if (e.chkPc4) chk("IF_ID_PC4", e.idx, IF_ID_PC4, e.pc4);
        end
    endtask

    task automatic step(input logic rst, input logic stall, input logic br, input logic [31:0] tgt,
                        input logic iv, input logic [31:0] data, input logic req, input logic [31:0] addr,
                        input logic [31:0] instr, input logic [31:0] pc4, input logic c, input logic valid);
        applyVec(mk(rst, stall, br, tgt, iv, data, req, addr, instr, pc4, c, valid));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, sequential fetch, stall into HOLD, reset mid-request, branch into DROP.
        vecs.push_back(mk(0,0,0,0,     0,0,             0,0,     0,0,1,0));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,0,     0,0,1,0));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,0,     0,0,1,0));
        vecs.push_back(mk(1,0,0,0,     1,memWord(0),    1,4,     memWord(0),4,1,1));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,4,     memWord(0),4,1,1));
        vecs.push_back(mk(1,0,0,0,     1,memWord(4),    1,8,     memWord(4),8,1,1));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,8,     memWord(4),8,1,1));
        vecs.push_back(mk(1,1,0,0,     1,memWord(8),    0,8,     memWord(4),8,1,1));
        vecs.push_back(mk(1,1,0,0,     1,32'hDEADBEEF,  0,8,     memWord(4),8,1,1));
        vecs.push_back(mk(1,1,0,0,     0,0,             0,8,     memWord(4),8,1,1));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,12,    memWord(8),12,1,1));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,12,    memWord(8),12,1,1));
        vecs.push_back(mk(1,1,0,0,     0,0,             1,12,    memWord(8),12,1,1));
        vecs.push_back(mk(1,0,0,0,     1,memWord(12),   1,16,    memWord(12),16,1,1));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,16,    memWord(12),16,1,1));
        vecs.push_back(mk(0,0,0,0,     1,memWord(16),   0,0,     0,0,1,0));
        vecs.push_back(mk(1,0,0,0,     1,memWord(16),   1,0,     0,0,1,0));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,0,     0,0,1,0));
        vecs.push_back(mk(1,0,0,0,     1,memWord(0),    1,4,     memWord(0),4,1,1));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,4,     memWord(0),4,1,1));
        vecs.push_back(mk(1,0,0,0,     1,memWord(4),    1,8,     memWord(4),8,1,1));
        vecs.push_back(mk(1,0,1,32'h40,0,0,             0,32'h40,0,0,0,0));
        vecs.push_back(mk(1,0,1,32'h83,0,0,             0,32'h80,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,memWord(8),    1,32'h80,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,     0,0,             1,32'h80,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,     1,memWord(32'h80),1,32'h84,memWord(32'h80),32'h84,1,1));

        for (int i = 0; i < vecs.size(); i++) begin
            applyVec(vecs[i]);
        end

        // Branch coincident with returned data: word is dropped, redirect to the top of memory.
        step(1,0,0,0,            0,0,                     1,32'h84,      memWord(32'h80),32'h84,1,1);
        step(1,0,1,32'hFFFFFFFC, 1,memWord(32'h84),       1,32'hFFFFFFFC,0,0,0,0);
        step(1,0,0,0,            0,0,                     1,32'hFFFFFFFC,0,0,0,0);
        // Fetch at the last word: PC+4 wraps to zero.
        step(1,0,0,0,            1,memWord(32'hFFFFFFFC), 1,0,           memWord(32'hFFFFFFFC),0,1,1);
        step(1,0,0,0,            0,0,                     1,0,           memWord(32'hFFFFFFFC),0,1,1);
        // Branch together with stall while in HOLD.
        step(1,1,0,0,            1,memWord(0),            0,0,           memWord(32'hFFFFFFFC),0,1,1);
        step(1,1,1,32'h100,      0,0,                     1,32'h100,     0,0,0,0);
        step(1,0,0,0,            0,0,                     1,32'h100,     0,0,0,0);
        step(1,0,0,0,            1,memWord(32'h100),      1,32'h104,     memWord(32'h100),32'h104,1,1);
        // Branch overrides stall with a request outstanding, then DROP discards the late word.
        step(1,1,1,32'h200,      0,0,                     0,32'h200,     0,0,0,0);
        step(1,1,0,0,            1,32'h12345678,          1,32'h200,     0,0,0,0);
        step(1,0,0,0,            0,0,                     1,32'h200,     0,0,0,0);
        step(1,0,0,0,            1,memWord(32'h200),      1,32'h204,     memWord(32'h200),32'h204,1,1);

        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
